// File: rtl/seg7_pkg.sv
// Shared constants and types for the multiplexed 8-digit 7-segment scan interface.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEL_IDLE  = 8'hFF;

  // Active-low gfedcba patterns for hex digits 0..F, decimal point (bit7) off.
  localparam logic [7:0] SEG_PAT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef logic [2:0] digit_idx_t;

  typedef struct packed {
    logic       blank;
    logic       err;
    digit_idx_t idx;
  } sel_dec_t;

  // One-cold select to digit index; no zero bits is blank, several is an error.
  function automatic sel_dec_t sel_decode(input logic [7:0] sel);
    sel_dec_t    d;
    int unsigned zeros;
    d     = '0;
    zeros = 0;
    for (int i = 0; i < 8; i++) begin
      if (!sel[i]) begin
        zeros += 1;
        d.idx  = digit_idx_t'(i);
      end
    end
    d.blank = (zeros == 0);
    d.err   = (zeros > 1);
    return d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 7-segment pattern to hex nibble decoder; decimal point ignored.
module seg7_decode (
  input  logic [7:0] seg,
  output logic       ok_c,
  output logic [3:0] nib_c
);
  import seg7_pkg::*;

  logic [7:0]  seg_n;
  logic [15:0] match;

  // Parallel compare against every pattern; at most one can hit, so OR-ing indices is safe.
  always_comb begin
    seg_n = seg | 8'h80;
    match = '0;
    nib_c = '0;
    for (int k = 0; k < 16; k++) begin
      match[k] = (seg_n == SEG_PAT[k]);
      if (match[k]) nib_c = nib_c | 4'(k);
    end
    ok_c = |match;
  end

endmodule

// File: rtl/seg7_capture.sv
// Samples the active-low scan lines of the display driver and reassembles the
// displayed 32-bit word, with settle filtering and malformed-sample reporting.
module seg7_capture #(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned FCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        i_seg,
  input  logic [7:0]        i_sel,
  output logic [31:0]       o_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [7:0]        o_mask,
  output logic [FCNT_W-1:0] o_frames
);
  import seg7_pkg::*;

  localparam logic [7:0] CNT_MAX = 8'(SETTLE);
  localparam logic [7:0] CNT_HIT = 8'(SETTLE - 1);

  logic [7:0]  r_seg, r_sel, p_seg, p_sel;
  logic [7:0]  cnt;
  logic [31:0] shadow, shadow_nx;
  logic [7:0]  mask_nx;
  logic        stable, strobe;
  logic        pat_ok;
  logic [3:0]  nib;
  sel_dec_t    sel_d;

  seg7_decode u_decode (
    .seg   (r_seg),
    .ok_c  (pat_ok),
    .nib_c (nib)
  );

  always_comb begin
    stable    = (r_seg == p_seg) && (r_sel == p_sel);
    strobe    = stable && (cnt == CNT_HIT);
    sel_d     = sel_decode(r_sel);
    shadow_nx = shadow;
    shadow_nx[{sel_d.idx, 2'b00} +: 4] = nib;
    mask_nx   = o_mask | (8'd1 << sel_d.idx);
  end

  // Input pipeline, settle counter and frame assembly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_seg    <= SEG_BLANK;
      p_seg    <= SEG_BLANK;
      r_sel    <= SEL_IDLE;
      p_sel    <= SEL_IDLE;
      cnt      <= '0;
      shadow   <= '0;
      o_data   <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
      o_mask   <= '0;
      o_frames <= '0;
    end else begin
      r_seg   <= i_seg;
      r_sel   <= i_sel;
      p_seg   <= r_seg;
      p_sel   <= r_sel;
      o_valid <= 1'b0;
      o_err   <= 1'b0;

      if (!stable)            cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;

      if (strobe && !sel_d.blank) begin
        if (sel_d.err || !pat_ok) begin
          o_err  <= 1'b1;
          o_mask <= '0;
        end else begin
          shadow <= shadow_nx;
          if (mask_nx == 8'hFF) begin
            o_data   <= shadow_nx;
            o_valid  <= 1'b1;
            o_mask   <= '0;
            o_frames <= o_frames + FCNT_W'(1);
          end else begin
            o_mask <= mask_nx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: drives scan sequences with the driver's sel/seg skew.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  i_seg, i_sel;
  logic [31:0] o_data;
  logic        o_valid, o_err;
  logic [7:0]  o_mask;
  logic [15:0] o_frames;

  int nvec = 0;
  int nmis = 0;
  int nvalid = 0;
  int nerr = 0;
  int v0, e0;

  logic [7:0] pat [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  seg7_capture #(.SETTLE(4), .FCNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .i_seg    (i_seg),
    .i_sel    (i_sel),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_mask   (o_mask),
    .o_frames (o_frames)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_valid) nvalid++;
    if (o_err)   nerr++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Each digit: select changes first, segments follow one cycle later.
  task automatic scan(input logic [31:0] w, input int first, input int last, input int dwell);
    for (int d = first; d <= last; d++) begin
      i_sel = ~(8'd1 << d);
      @(negedge clk);
      i_seg = pat[w[4*d +: 4]];
      repeat (dwell - 1) @(negedge clk);
    end
  endtask

  task automatic idle();
    i_sel = 8'hFF;
    @(negedge clk);
    i_seg = 8'hFF;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    i_seg = 8'hFF;
    i_sel = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_data",   o_data,   32'h0);
    chk("rst_valid",  32'(o_valid), 32'h0);
    chk("rst_err",    32'(o_err),   32'h0);
    chk("rst_mask",   32'(o_mask),  32'h0);
    chk("rst_frames", 32'(o_frames), 32'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("idle_mask", 32'(o_mask), 32'h0);

    // Full frame at comfortable dwell.
    v0 = nvalid; e0 = nerr;
    scan(32'h1234ABCD, 0, 7, 10);
    idle();
    repeat (3) @(negedge clk);
    chk("f1_data",   o_data, 32'h1234ABCD);
    chk("f1_frames", 32'(o_frames), 32'd1);
    chk("f1_nvalid", 32'(nvalid - v0), 32'd1);
    chk("f1_nerr",   32'(nerr - e0), 32'd0);
    chk("f1_mask",   32'(o_mask), 32'h0);

    // Bad pattern on digit 3 mid-frame, latency measured from a clean pin change.
    scan(32'h98765432, 0, 2, 10);
    chk("pe_mask_pre", 32'(o_mask), 32'h07);
    e0 = nerr;
    i_sel = 8'b1111_0111;
    i_seg = 8'hFF;
    repeat (5) @(negedge clk);
    chk("pe_err_early", 32'(o_err), 32'h0);
    @(negedge clk);
    chk("pe_err_at6",  32'(o_err), 32'h1);
    chk("pe_mask",     32'(o_mask), 32'h0);
    chk("pe_data",     o_data, 32'h1234ABCD);
    @(negedge clk);
    chk("pe_err_after", 32'(o_err), 32'h0);
    chk("pe_nerr",      32'(nerr - e0), 32'd1);

    // Long hold: single capture, never resampled.
    e0 = nerr; v0 = nvalid;
    i_sel = 8'b1101_1111;
    i_seg = pat[14];
    repeat (40) @(negedge clk);
    chk("hold_mask", 32'(o_mask), 32'h20);
    chk("hold_nerr", 32'(nerr - e0), 32'd0);
    chk("hold_nval", 32'(nvalid - v0), 32'd0);

    // Two selects active at once.
    e0 = nerr;
    i_sel = 8'b1111_0011;
    repeat (6) @(negedge clk);
    chk("se_err",    32'(o_err), 32'h1);
    chk("se_mask",   32'(o_mask), 32'h0);
    chk("se_data",   o_data, 32'h1234ABCD);
    chk("se_frames", 32'(o_frames), 32'd1);
    repeat (20) @(negedge clk);
    chk("se_nerr",   32'(nerr - e0), 32'd1);

    // Dwell too short: nothing captured.
    e0 = nerr; v0 = nvalid;
    scan(32'h89ABCDEF, 0, 7, 5);
    idle();
    repeat (3) @(negedge clk);
    chk("d5_mask",   32'(o_mask), 32'h0);
    chk("d5_frames", 32'(o_frames), 32'd1);
    chk("d5_nerr",   32'(nerr - e0), 32'd0);
    chk("d5_nval",   32'(nvalid - v0), 32'd0);

    // Minimum dwell: full capture.
    scan(32'h89ABCDEF, 0, 7, 6);
    idle();
    repeat (3) @(negedge clk);
    chk("d6_data",   o_data, 32'h89ABCDEF);
    chk("d6_frames", 32'(o_frames), 32'd2);
    chk("d6_mask",   32'(o_mask), 32'h0);

    // Reset after a partial frame discards it.
    scan(32'hDEADBEEF, 0, 4, 10);
    chk("pr_mask", 32'(o_mask), 32'h1F);
    reset = 1'b1;
    i_sel = 8'hFF;
    i_seg = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("pr_rst_mask",   32'(o_mask), 32'h0);
    chk("pr_rst_data",   o_data, 32'h0);
    chk("pr_rst_frames", 32'(o_frames), 32'd0);
    scan(32'hDEADBEEF, 0, 6, 10);
    chk("pr7_data", o_data, 32'h0);
    chk("pr7_mask", 32'(o_mask), 32'h7F);
    scan(32'hDEADBEEF, 7, 7, 10);
    idle();
    repeat (3) @(negedge clk);
    chk("pr8_data",   o_data, 32'hDEADBEEF);
    chk("pr8_frames", 32'(o_frames), 32'd1);
    chk("pr8_mask",   32'(o_mask), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
